coolgirl_cfg_regs: RTL
======================

Name: coolgirl_cfg_regs

Overview:
- Multicart configuration register file, upstream of the CoolGirl mapper core.
- Decodes CPU writes to $5000-$5FFF into shadow registers.
- A commit write to R5 transfers the shadows atomically to the live outputs that drive the core's PRG/CHR address, SRAM and strobe logic: cpu_base, prg_mask, chr_mask, the mapper select and the flags.
- Setting the lockout bit freezes the configuration until reset, so the loaded game cannot corrupt it.

Parameters:
- PRG_BASE_RESET, 13'h0000: live and shadow cpu_base[26:14] after reset.
- PRG_MASK_RESET, 7'b1111000: live and shadow prg_mask[20:14] after reset (128 KB menu window).
- CHR_MASK_RESET, 5'b11111: live and shadow chr_mask[17:13] after reset.

Ports:
- m2  input  1  CPU M2; sole clock; all flops update on its falling edge.
- rst_n  input  1  asynchronous active-low reset.
- romsel  input  1  CPU /ROMSEL; high selects the $0000-$7FFF decode space.
- cpu_rw_in  input  1  1 = read, 0 = write.
- cpu_addr_in  input  15  CPU A14..A0.
- cpu_data_in  input  8  CPU data bus.
- cpu_base  output  13  live PRG base [26:14].
- prg_mask  output  7  live PRG mask [20:14].
- chr_mask  output  5  live CHR mask [17:13].
- mapper  output  6  live mapper select.
- sram_enabled, map_rom_on_6000, prg_write_enabled, chr_write_enabled, four_screen  output  1 each  live flags.
- sram_page  output  2  live SRAM page.
- lockout  output  1  configuration frozen.
- cfg_pending  output  1  shadow differs from live (staged, not committed).
- cpu_data_out  output  8  readback data (READBACK_EN only; 0 otherwise).
- cpu_data_out_enabled  output  1  readback drive enable (READBACK_EN only; 0 otherwise).

Behaviour:
- Write hit:
  - romsel=1, cpu_addr_in[14:12]=3'b101, cpu_rw_in=0 at the falling edge of m2.
  - Register index = cpu_addr_in[2:0]; A11..A3 are don't-care (mirrored).
- Register map (shadow registers):
  - R0: cpu_base[26:19] = D[7:0].
  - R1: cpu_base[18:14] = D[7:3].
  - R2: prg_mask = D[6:0].
  - R3: chr_mask = D[4:0].
  - R4: mapper = D[5:0].
  - R5 (commit): D0 sram_enabled, D1 map_rom_on_6000, D2 prg_write_enabled, D3 chr_write_enabled, D4 four_screen, D6:5 sram_page, D7 lockout.
  - Indices 6 and 7: ignored, no state change.
- State machine (2 bits):
  - IDLE: R0-R4 write → STAGED. R5 write → commit, stay IDLE (or go LOCKED if D7=1).
  - STAGED: R0-R4 write → STAGED. R5 write → commit → IDLE, or LOCKED if D7=1.
  - LOCKED: all writes ignored. Exit only via rst_n.
- Commit:
  - On the same falling edge, all live outputs take the shadow values, with the R5 fields taken from the current data.
  - Latency: outputs valid after that edge; zero extra cycles.
  - A write to R0-R4 never changes live outputs.
- cfg_pending = (state == STAGED).
- Reset (async, any time, including mid-sequence):
  - State IDLE; shadows and live cpu_base/prg_mask/chr_mask = parameters.
  - mapper = 0.
  - chr_write_enabled = 1; prg_write_enabled = 1; all other flags = 0.
  - sram_page = 0; lockout = 0; cpu_data_out = 0; cpu_data_out_enabled = 0.
- Back-to-back writes to the same register: last wins.
- Write while romsel=0 or outside $5xxx: ignored.
- R5 write with D7=1 while in IDLE: commit and lock on the same edge.

Optional Feature:
- COOLGIRL_CFG_READBACK_EN defined:
  - A read hit (same decode, cpu_rw_in=1, m2=1) of R0-R5 asserts cpu_data_out_enabled combinationally.
  - cpu_data_out = shadow value in register format, unused bits 0.
  - R5 returns the live flags plus lockout.
  - Readback is allowed when LOCKED.
- Undefined: cpu_data_out_enabled tied 0, cpu_data_out tied 0.

Decomposition:
- Package coolgirl_cfg_pkg holds:
  - register index constants CFG_R0..CFG_R5;
  - decode constant CFG_PAGE = 3'b101;
  - state enum {CFG_IDLE, CFG_STAGED, CFG_LOCKED};
  - R5 flag bit positions.
- One natural sub-module, coolgirl_cfg_decode: combinational write/read-hit and index decode.

Test Plan:
- Reset → cpu_base=0, prg_mask=7'b1111000, chr_mask=5'b11111, chr_write_enabled=1, prg_write_enabled=1, lockout=0, cfg_pending=0.
- Write $5000=8'h12, $5001=8'hA8, then check live outputs → cpu_base unchanged, cfg_pending=1. Then write $5005=8'h05 → cpu_base=13'h0255, sram_enabled=1, map_rom_on_6000=0, prg_write_enabled=1, cfg_pending=0.
- Write $5FF4=8'h3F (mirror), then $5005=8'h00 → mapper=6'h3F.
- Write $5005=8'h80, then $5002=8'h00, then $5005=8'h00 → lockout=1, prg_mask unchanged, state LOCKED.
- Stage $5003=8'h07, pulse rst_n low mid-cycle → chr_mask=5'b11111, cfg_pending=0. A later $5005 commit with no staged writes → chr_mask stays 5'b11111.
- READBACK_EN: write $5002=8'h0F, read $5002 → cpu_data_out=8'h0F, cpu_data_out_enabled=1 only during m2=1. Read $5006 → cpu_data_out_enabled=0.

Source files
------------

// File: rtl/coolgirl_cfg_pkg.sv
// Shared constants for the CoolGirl configuration register file: decode page,
// register indices, controller states and R5 flag bit positions.
package coolgirl_cfg_pkg;

  localparam logic [2:0] CFG_PAGE = 3'b101;

  localparam logic [2:0] CFG_R0 = 3'd0;
  localparam logic [2:0] CFG_R1 = 3'd1;
  localparam logic [2:0] CFG_R2 = 3'd2;
  localparam logic [2:0] CFG_R3 = 3'd3;
  localparam logic [2:0] CFG_R4 = 3'd4;
  localparam logic [2:0] CFG_R5 = 3'd5;

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_STAGED = 2'd1,
    CFG_LOCKED = 2'd2
  } cfg_state_t;

  localparam int R5_SRAM_EN   = 0;
  localparam int R5_MAP_6000  = 1;
  localparam int R5_PRG_WE    = 2;
  localparam int R5_CHR_WE    = 3;
  localparam int R5_FOUR_SCR  = 4;
  localparam int R5_PAGE_LO   = 5;
  localparam int R5_PAGE_HI   = 6;
  localparam int R5_LOCK      = 7;

  // True for the registers that only stage shadow state.
  function automatic logic is_shadow_idx(input logic [2:0] idx);
    return idx <= CFG_R4;
  endfunction

endpackage

// File: rtl/coolgirl_cfg_decode.sv
// Combinational CPU decode of the $5000-$5FFF config page: write hit,
// read hit (only while M2 is high) and register index. A11..A3 are mirrored.
module coolgirl_cfg_decode
  import coolgirl_cfg_pkg::*;
(
  input  logic        m2,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  output logic        wr_hit,
  output logic        rd_hit,
  output logic [2:0]  reg_idx
);

  logic page_hit;
  logic unused_addr;

  assign page_hit    = romsel && (cpu_addr_in[14:12] == CFG_PAGE);
  assign wr_hit      = page_hit && !cpu_rw_in;
  assign rd_hit      = page_hit && cpu_rw_in && m2;
  assign reg_idx     = cpu_addr_in[2:0];
  assign unused_addr = ^cpu_addr_in[11:3];

endmodule

// File: rtl/coolgirl_cfg_regs.sv
// CoolGirl multicart configuration registers: shadow staging, atomic commit on
// R5, lockout until reset. Readback is built only with COOLGIRL_CFG_READBACK_EN.
module coolgirl_cfg_regs
  import coolgirl_cfg_pkg::*;
#(
  parameter logic [12:0] PRG_BASE_RESET = 13'h0000,
  parameter logic [6:0]  PRG_MASK_RESET = 7'b1111000,
  parameter logic [4:0]  CHR_MASK_RESET = 5'b11111
) (
  input  logic        m2,
  input  logic        rst_n,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  output logic [12:0] cpu_base,
  output logic [6:0]  prg_mask,
  output logic [4:0]  chr_mask,
  output logic [5:0]  mapper,
  output logic        sram_enabled,
  output logic        map_rom_on_6000,
  output logic        prg_write_enabled,
  output logic        chr_write_enabled,
  output logic        four_screen,
  output logic [1:0]  sram_page,
  output logic        lockout,
  output logic        cfg_pending,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_out_enabled
);

  logic        wr_hit;
  logic        rd_hit;
  logic [2:0]  reg_idx;

  cfg_state_t  state;
  logic [12:0] sh_base;
  logic [6:0]  sh_prg_mask;
  logic [4:0]  sh_chr_mask;
  logic [5:0]  sh_mapper;

  coolgirl_cfg_decode u_decode (
    .m2          (m2),
    .romsel      (romsel),
    .cpu_rw_in   (cpu_rw_in),
    .cpu_addr_in (cpu_addr_in),
    .wr_hit      (wr_hit),
    .rd_hit      (rd_hit),
    .reg_idx     (reg_idx)
  );

  // All state moves on the falling edge of M2, when CPU address/data are stable.
  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      state             <= CFG_IDLE;
      sh_base           <= PRG_BASE_RESET;
      sh_prg_mask       <= PRG_MASK_RESET;
      sh_chr_mask       <= CHR_MASK_RESET;
      sh_mapper         <= 6'd0;
      cpu_base          <= PRG_BASE_RESET;
      prg_mask          <= PRG_MASK_RESET;
      chr_mask          <= CHR_MASK_RESET;
      mapper            <= 6'd0;
      sram_enabled      <= 1'b0;
      map_rom_on_6000   <= 1'b0;
      prg_write_enabled <= 1'b1;
      chr_write_enabled <= 1'b1;
      four_screen       <= 1'b0;
      sram_page         <= 2'd0;
    end else if (wr_hit && (state != CFG_LOCKED)) begin
      if (is_shadow_idx(reg_idx)) begin
        state <= CFG_STAGED;
      end
      case (reg_idx)
        CFG_R0: sh_base[12:5] <= cpu_data_in;
        CFG_R1: sh_base[4:0]  <= cpu_data_in[7:3];
        CFG_R2: sh_prg_mask   <= cpu_data_in[6:0];
        CFG_R3: sh_chr_mask   <= cpu_data_in[4:0];
        CFG_R4: sh_mapper     <= cpu_data_in[5:0];
        CFG_R5: begin
          cpu_base          <= sh_base;
          prg_mask          <= sh_prg_mask;
          chr_mask          <= sh_chr_mask;
          mapper            <= sh_mapper;
          sram_enabled      <= cpu_data_in[R5_SRAM_EN];
          map_rom_on_6000   <= cpu_data_in[R5_MAP_6000];
          prg_write_enabled <= cpu_data_in[R5_PRG_WE];
          chr_write_enabled <= cpu_data_in[R5_CHR_WE];
          four_screen       <= cpu_data_in[R5_FOUR_SCR];
          sram_page         <= cpu_data_in[R5_PAGE_HI:R5_PAGE_LO];
          state             <= cpu_data_in[R5_LOCK] ? CFG_LOCKED : CFG_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign cfg_pending = (state == CFG_STAGED);
  assign lockout     = (state == CFG_LOCKED);

`ifdef COOLGIRL_CFG_READBACK_EN
  logic [7:0] rb_data;
  logic       rb_en;

  // Shadows read back in register format; R5 reflects the live flags.
  always_comb begin
    rb_data = 8'h00;
    rb_en   = 1'b0;
    if (rd_hit) begin
      rb_en = 1'b1;
      case (reg_idx)
        CFG_R0:  rb_data = sh_base[12:5];
        CFG_R1:  rb_data = {sh_base[4:0], 3'b000};
        CFG_R2:  rb_data = {1'b0, sh_prg_mask};
        CFG_R3:  rb_data = {3'b000, sh_chr_mask};
        CFG_R4:  rb_data = {2'b00, sh_mapper};
        CFG_R5:  rb_data = {lockout, sram_page, four_screen, chr_write_enabled,
                            prg_write_enabled, map_rom_on_6000, sram_enabled};
        default: rb_en = 1'b0;
      endcase
    end
  end

  assign cpu_data_out         = rb_data;
  assign cpu_data_out_enabled = rb_en;
`else
  logic unused_rd;
  assign unused_rd            = rd_hit;
  assign cpu_data_out         = 8'h00;
  assign cpu_data_out_enabled = 1'b0;
`endif

endmodule
